cam_capture: RTL and testbench
==============================

# cam_capture

Camera-side capture stage that feeds the frame buffer read by the 640x480@60 VGA output path. It samples an OV7670-style 8-bit parallel camera bus (VSYNC/HREF/D[7:0]) and assembles byte pairs into RGB565 pixels. It converts each pixel to 12-bit RGB444 and emits one write strobe per pixel with a linear frame-buffer address (`waddr_cam`). It also reports frame completion and frame-length errors so the display side can trust the buffer contents.

## Interface
Parameters:
- `HPIX`, 640, active pixels per line.
- `VPIX`, 480, active lines per frame.
- `AW`, 19, address width; must satisfy 2^AW >= HPIX*VPIX.

Ports:
- `pixel_clk`  in  1  camera PCLK; sole clock, all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cam_vsync`  in  1  camera VSYNC; high = vertical blanking.
- `cam_href`  in  1  camera HREF; high = active line bytes valid.
- `cam_data`  in  8  camera pixel byte.
- `enable`  in  1  capture enable; sampled only at frame start.
- `waddr_cam`  out  AW  frame-buffer write address.
- `wdata`  out  12  RGB444 pixel, {R[3:0],G[3:0],B[3:0]}.
- `we`  out  1  write strobe, one cycle per pixel.
- `frame_done`  out  1  one-cycle pulse at end of each captured frame.
- `frame_err`  out  1  valid with `frame_done`; pixel count != expected.
- `overflow`  out  1  sticky; pixels dropped past buffer end this frame.

## Operation
- Input stage: `cam_vsync`, `cam_href` and `cam_data` are registered once (s1). All decisions use the s1 values. The previous-cycle `vsync_s1` is kept for edge detection.
- FSM states:
  - `IDLE`: entered on reset. Waits for a vsync rising edge, then goes to `WAIT_START`. This prevents capture of a partial first frame.
  - `WAIT_START`: on a vsync falling edge, if `enable`=1, go to `CAPTURE`; zero the pixel count, address, column/line counters, `overflow` and byte phase. If `enable`=0, stay in `WAIT_START`.
  - `CAPTURE`: while `href_s1`=1, bytes alternate phase 0/1.
    - Phase 0 byte is latched as `hi`.
    - Phase 1 byte `lo` completes a pixel: R=`hi[7:4]`, G={`hi[2:0]`,`lo[7]`}, B=`lo[4:1]`.
    - On vsync rising edge: pulse `frame_done`, go to `WAIT_START`.
- Href falling edge resets the byte phase to 0. A dangling phase-0 byte is discarded and the line counter increments.
- Pixel write: `we`=1 with `wdata` and `waddr_cam` = current address. The address then increments by 1.
- Boundary: when address = HPIX*VPIX the pixel is not written (`we` stays 0), `overflow` sets, and the count still increments.
- `frame_err` = (pixel count != HPIX*VPIX), registered with `frame_done`.
- Reset mid-frame: all state clears asynchronously, FSM returns to `IDLE`, and the next full frame is captured.
- Simultaneous href=1 and vsync rising: vsync wins; the byte is ignored.

## Timing
- Reset values: `waddr_cam`=0, `wdata`=0, `we`=0, `frame_done`=0, `frame_err`=0, `overflow`=0, FSM=`IDLE`.
- Latency: phase-1 byte at pins on edge N gives `we`=1 with its pixel on edge N+2.
- Sustained rate: 1 write every 2 cycles while href is high; `we` is never high on consecutive cycles.
- `frame_done` is asserted 2 cycles after vsync rises at the pins. `frame_err` is valid in the same cycle.
- `waddr_cam` holds its last written value + 1 between writes and across blanking.

## Configuration
- `CAM_DECIMATE_EN` defined: writes only pixels with even column and even line index (320x240).
  - Address range is 0..HPIX*VPIX/4-1.
  - `frame_err` compares the written count against HPIX*VPIX/4.
  - `overflow` sets beyond HPIX*VPIX/4.
  - Dropped pixels produce no `we`.
- Undefined: full-resolution capture as above.

## Test plan
- Reset, then one clean 640x480 frame of bytes 0xF8,0x1F repeated -> 307200 writes, `wdata`=0xF0F, last address 307199, `frame_done`=1, `frame_err`=0.
- Assert `rst` at line 100 of a frame -> outputs return to reset values immediately; that frame and its `frame_done` are suppressed; next full frame captured from address 0.
- Frame with 481 lines -> 307200 writes, `overflow`=1, `frame_err`=1; `overflow` clears at the next frame start.
- Line with 1281 bytes (odd) -> 640 writes; next line starts at address 640 with the correct byte pairing.
- `enable`=0 at vsync falling -> zero writes for that frame; `enable`=1 at the next frame -> capture resumes.
- With `CAM_DECIMATE_EN`, clean frame whose pixel value is its column index -> 76800 writes, every `wdata` derived from an even column, `frame_err`=0.

Source files
------------

// File: rtl/cam_capture.sv
// OV7670-style camera capture: byte pairs -> RGB565 -> RGB444 frame-buffer writes.
// Optional CAM_DECIMATE_EN keeps only even-column/even-line pixels (quarter resolution).
module cam_capture #(
    parameter int HPIX = 640,
    parameter int VPIX = 480,
    parameter int AW   = 19
) (
    input  logic          pixel_clk,
    input  logic          rst,
    input  logic          cam_vsync,
    input  logic          cam_href,
    input  logic [7:0]    cam_data,
    input  logic          enable,
    output logic [AW-1:0] waddr_cam,
    output logic [11:0]   wdata,
    output logic          we,
    output logic          frame_done,
    output logic          frame_err,
    output logic          overflow
);

`ifdef CAM_DECIMATE_EN
    localparam int NPIX = HPIX * VPIX / 4;
`else
    localparam int NPIX = HPIX * VPIX;
`endif
    localparam int CW = AW + 2;
    localparam logic [AW:0]   LIMIT    = (AW+1)'(NPIX);
    localparam logic [CW-1:0] EXP_CNT  = CW'(NPIX);

    typedef enum logic [1:0] {IDLE, WAIT_START, CAPTURE} state_t;

    state_t        state;
    logic          vsync_s1, href_s1, vsync_d, href_d;
    logic [7:0]    data_s1;
    logic [6:0]    hi;        // {R[4:1], G[5:3]} of the pending pixel
    logic          phase;
    logic [AW:0]   addr;      // one extra bit so the end-of-buffer value is representable
    logic [CW-1:0] pix_cnt;
    logic          keep;
    logic          vs_rise, vs_fall, href_fall;
    logic [11:0]   rgb;

    assign vs_rise   = vsync_s1 & ~vsync_d;
    assign vs_fall   = ~vsync_s1 & vsync_d;
    assign href_fall = ~href_s1 & href_d;
    assign rgb       = {hi[6:3], hi[2:0], data_s1[7], data_s1[4:1]};
    assign waddr_cam = addr[AW-1:0];

`ifdef CAM_DECIMATE_EN
    logic col_odd, line_odd;
    assign keep = ~col_odd & ~line_odd;
`else
    assign keep = 1'b1;
`endif

    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            vsync_s1   <= 1'b0;
            href_s1    <= 1'b0;
            data_s1    <= '0;
            vsync_d    <= 1'b0;
            href_d     <= 1'b0;
            hi         <= '0;
            phase      <= 1'b0;
            addr       <= '0;
            pix_cnt    <= '0;
            wdata      <= '0;
            we         <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
`ifdef CAM_DECIMATE_EN
            col_odd    <= 1'b0;
            line_odd   <= 1'b0;
`endif
        end else begin
            vsync_s1   <= cam_vsync;
            href_s1    <= cam_href;
            data_s1    <= cam_data;
            vsync_d    <= vsync_s1;
            href_d     <= href_s1;
            we         <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            // Address advances the cycle after a write, so waddr_cam is valid while we is high.
            if (we)
                addr <= addr + 1'b1;

            case (state)
                IDLE: begin
                    if (vs_rise)
                        state <= WAIT_START;
                end
                WAIT_START: begin
                    if (vs_fall && enable) begin
                        state    <= CAPTURE;
                        addr     <= '0;
                        pix_cnt  <= '0;
                        overflow <= 1'b0;
                        phase    <= 1'b0;
`ifdef CAM_DECIMATE_EN
                        col_odd  <= 1'b0;
                        line_odd <= 1'b0;
`endif
                    end
                end
                CAPTURE: begin
                    if (vs_rise) begin
                        frame_done <= 1'b1;
                        frame_err  <= (pix_cnt != EXP_CNT);
                        state      <= WAIT_START;
                    end else if (href_s1) begin
                        if (!phase) begin
                            hi    <= {data_s1[7:4], data_s1[2:0]};
                            phase <= 1'b1;
                        end else begin
                            phase <= 1'b0;
                            if (keep) begin
                                pix_cnt <= pix_cnt + 1'b1;
                                if (addr == LIMIT) begin
                                    overflow <= 1'b1;
                                end else begin
                                    we    <= 1'b1;
                                    wdata <= rgb;
                                end
                            end
`ifdef CAM_DECIMATE_EN
                            col_odd <= ~col_odd;
`endif
                        end
                    end else if (href_fall) begin
                        // A dangling high byte at line end is dropped here.
                        phase <= 1'b0;
`ifdef CAM_DECIMATE_EN
                        col_odd  <= 1'b0;
                        line_odd <= ~line_odd;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cam_capture.sv
// Directed bench for cam_capture on a small 8x4 frame; covers CAM_DECIMATE_EN when defined.
module tb_cam_capture;

    localparam int HP = 8;
    localparam int VP = 4;
    localparam int AW = 6;

    logic          pixel_clk = 1'b0;
    logic          rst = 1'b0;
    logic          cam_vsync = 1'b0;
    logic          cam_href = 1'b0;
    logic [7:0]    cam_data = '0;
    logic          enable = 1'b0;
    logic [AW-1:0] waddr_cam;
    logic [11:0]   wdata;
    logic          we, frame_done, frame_err, overflow;

    cam_capture #(.HPIX(HP), .VPIX(VP), .AW(AW)) dut (
        .pixel_clk(pixel_clk), .rst(rst), .cam_vsync(cam_vsync), .cam_href(cam_href),
        .cam_data(cam_data), .enable(enable), .waddr_cam(waddr_cam), .wdata(wdata),
        .we(we), .frame_done(frame_done), .frame_err(frame_err), .overflow(overflow)
    );

    always #5 pixel_clk = ~pixel_clk;

    int checks = 0, errors = 0;
    int cyc = 0;
    int mode = 0;
    int wr_cnt = 0, done_cnt = 0, data_err = 0, addr_err = 0, consec = 0, exp_addr = 0;
    int first_we_cyc = 0, lo_cyc = 0;
    logic [AW-1:0] last_addr = '0;
    logic [11:0]   last_data = '0;
    bit prev_we = 1'b0;

    always @(posedge pixel_clk) cyc++;

    function automatic logic [7:0] byte_hi(int l, int c);
        case (mode)
            0:       return 8'hF8;
            1:       return 8'(c * 37 + l * 11 + 3);
            default: return 8'(c << 4);
        endcase
    endfunction

    function automatic logic [7:0] byte_lo(int l, int c);
        case (mode)
            0:       return 8'h1F;
            1:       return 8'(c * 53 + l * 7 + 5);
            default: return 8'(c << 1);
        endcase
    endfunction

    function automatic logic [11:0] exp_pix(int a);
        int l, c;
        logic [7:0] h, lo;
`ifdef CAM_DECIMATE_EN
        l = 2 * (a / (HP / 2));
        c = 2 * (a % (HP / 2));
`else
        l = a / HP;
        c = a % HP;
`endif
        h  = byte_hi(l, c);
        lo = byte_lo(l, c);
        return {h[7:4], h[2:0], lo[7], lo[4:1]};
    endfunction

    always @(negedge pixel_clk) begin
        if (we) begin
            if (wr_cnt == 0) first_we_cyc = cyc;
            if (prev_we) consec++;
            if (waddr_cam !== AW'(exp_addr)) addr_err++;
            if (wdata !== exp_pix(int'(waddr_cam))) data_err++;
            exp_addr++;
            wr_cnt++;
            last_addr = waddr_cam;
            last_data = wdata;
        end
        prev_we = we;
        if (frame_done) done_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic run_frame(input int nlines, input int odd_line, input int rst_line,
                             input bit en, input bit chk_ovf, output bit fd, output bit fe);
        int nb;
        cam_href = 1'b0;
        @(negedge pixel_clk) cam_vsync = 1'b1; enable = en;
        repeat (4) @(negedge pixel_clk);
        cam_vsync = 1'b0;
        wr_cnt = 0; data_err = 0; addr_err = 0; consec = 0; exp_addr = 0;
        repeat (3) @(negedge pixel_clk);
        if (chk_ovf) begin
            checks++;
            if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b want 0", overflow); end
        end
        for (int l = 0; l < nlines; l++) begin
            if (l == rst_line) begin
                #2 rst = 1'b1;
                #1 checks++;
                if ({waddr_cam, wdata, we, frame_done, frame_err, overflow} !== '0) begin
                    errors++;
                    $display("FAIL async_reset got addr=%0d data=%h we=%b fd=%b fe=%b ovf=%b want all 0",
                             waddr_cam, wdata, we, frame_done, frame_err, overflow);
                end
                @(negedge pixel_clk) rst = 1'b0;
            end
            nb = 2 * HP + ((l == odd_line) ? 1 : 0);
            for (int b = 0; b < nb; b++) begin
                @(negedge pixel_clk);
                cam_href = 1'b1;
                cam_data = (b % 2 == 0) ? byte_hi(l, b / 2) : byte_lo(l, b / 2);
                if (l == 0 && b == 1) lo_cyc = cyc;
            end
            @(negedge pixel_clk) cam_href = 1'b0;
            repeat (3) @(negedge pixel_clk);
        end
        @(negedge pixel_clk) cam_vsync = 1'b1;
        @(negedge pixel_clk);
        @(negedge pixel_clk);
        fd = frame_done;
        fe = frame_err;
        repeat (2) @(negedge pixel_clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge pixel_clk);
        checks++; if (waddr_cam !== '0) begin errors++; $display("FAIL rst_waddr got %0d want 0", waddr_cam); end
        checks++; if (wdata !== '0) begin errors++; $display("FAIL rst_wdata got %h want 000", wdata); end
        checks++; if (we !== 1'b0) begin errors++; $display("FAIL rst_we got %b want 0", we); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", frame_done); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", frame_err); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b want 0", overflow); end
        rst = 1'b0;
        repeat (2) @(negedge pixel_clk);
    endtask

`ifdef CAM_DECIMATE_EN
    task automatic test_decimate;
        bit fd, fe;
        mode = 2;
        run_frame(VP, -1, -1, 1'b1, 1'b0, fd, fe);
        checks++; if (wr_cnt != HP * VP / 4) begin errors++; $display("FAIL dec_writes got %0d want %0d", wr_cnt, HP * VP / 4); end
        checks++; if (data_err != 0) begin errors++; $display("FAIL dec_data got %0d bad want 0", data_err); end
        checks++; if (addr_err != 0) begin errors++; $display("FAIL dec_addr got %0d bad want 0", addr_err); end
        checks++; if (last_addr !== AW'(HP * VP / 4 - 1)) begin errors++; $display("FAIL dec_last_addr got %0d want %0d", last_addr, HP * VP / 4 - 1); end
        checks++; if (fd !== 1'b1) begin errors++; $display("FAIL dec_done got %b want 1", fd); end
        checks++; if (fe !== 1'b0) begin errors++; $display("FAIL dec_err got %b want 0", fe); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL dec_ovf got %b want 0", overflow); end
    endtask
`else
    task automatic test_clean_frame;
        bit fd, fe;
        mode = 0;
        run_frame(VP, -1, -1, 1'b1, 1'b0, fd, fe);
        checks++; if (wr_cnt != HP * VP) begin errors++; $display("FAIL clean_writes got %0d want %0d", wr_cnt, HP * VP); end
        checks++; if (last_addr !== AW'(HP * VP - 1)) begin errors++; $display("FAIL clean_last_addr got %0d want %0d", last_addr, HP * VP - 1); end
        checks++; if (last_data !== 12'hF0F) begin errors++; $display("FAIL clean_wdata got %h want f0f", last_data); end
        checks++; if (data_err != 0) begin errors++; $display("FAIL clean_data got %0d bad want 0", data_err); end
        checks++; if (addr_err != 0) begin errors++; $display("FAIL clean_addr got %0d bad want 0", addr_err); end
        checks++; if (fd !== 1'b1) begin errors++; $display("FAIL clean_done got %b want 1", fd); end
        checks++; if (fe !== 1'b0) begin errors++; $display("FAIL clean_err got %b want 0", fe); end
        checks++; if (first_we_cyc - lo_cyc != 2) begin errors++; $display("FAIL latency got %0d want 2", first_we_cyc - lo_cyc); end
        checks++; if (consec != 0) begin errors++; $display("FAIL we_back_to_back got %0d want 0", consec); end
        checks++; if (waddr_cam !== AW'(HP * VP)) begin errors++; $display("FAIL addr_hold got %0d want %0d", waddr_cam, HP * VP); end
    endtask

    task automatic test_pattern;
        bit fd, fe;
        mode = 1;
        run_frame(VP, -1, -1, 1'b1, 1'b0, fd, fe);
        checks++; if (wr_cnt != HP * VP) begin errors++; $display("FAIL pat_writes got %0d want %0d", wr_cnt, HP * VP); end
        checks++; if (data_err != 0) begin errors++; $display("FAIL pat_data got %0d bad want 0", data_err); end
        checks++; if (fe !== 1'b0 || fd !== 1'b1) begin errors++; $display("FAIL pat_done got fd=%b fe=%b want 1 0", fd, fe); end
    endtask

    task automatic test_reset_midframe;
        bit fd, fe;
        int dc;
        mode = 1;
        dc = done_cnt;
        run_frame(VP, -1, 2, 1'b1, 1'b0, fd, fe);
        checks++; if (fd !== 1'b0 || done_cnt != dc) begin errors++; $display("FAIL rst_frame_done got fd=%b n=%0d want 0 %0d", fd, done_cnt, dc); end
        run_frame(VP, -1, -1, 1'b1, 1'b0, fd, fe);
        checks++; if (wr_cnt != HP * VP) begin errors++; $display("FAIL post_rst_writes got %0d want %0d", wr_cnt, HP * VP); end
        checks++; if (addr_err != 0 || data_err != 0) begin errors++; $display("FAIL post_rst_addr got a=%0d d=%0d bad want 0", addr_err, data_err); end
        checks++; if (fd !== 1'b1 || fe !== 1'b0) begin errors++; $display("FAIL post_rst_done got fd=%b fe=%b want 1 0", fd, fe); end
    endtask

    task automatic test_overflow;
        bit fd, fe;
        mode = 1;
        run_frame(VP + 1, -1, -1, 1'b1, 1'b0, fd, fe);
        checks++; if (wr_cnt != HP * VP) begin errors++; $display("FAIL ovf_writes got %0d want %0d", wr_cnt, HP * VP); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", overflow); end
        checks++; if (fe !== 1'b1 || fd !== 1'b1) begin errors++; $display("FAIL ovf_err got fd=%b fe=%b want 1 1", fd, fe); end
        run_frame(VP, -1, -1, 1'b1, 1'b1, fd, fe);
        checks++; if (fe !== 1'b0 || wr_cnt != HP * VP) begin errors++; $display("FAIL ovf_next got fe=%b n=%0d want 0 %0d", fe, wr_cnt, HP * VP); end
    endtask

    task automatic test_odd_line;
        bit fd, fe;
        mode = 1;
        run_frame(VP, 0, -1, 1'b1, 1'b0, fd, fe);
        checks++; if (wr_cnt != HP * VP) begin errors++; $display("FAIL odd_writes got %0d want %0d", wr_cnt, HP * VP); end
        checks++; if (addr_err != 0) begin errors++; $display("FAIL odd_addr got %0d bad want 0", addr_err); end
        checks++; if (data_err != 0) begin errors++; $display("FAIL odd_pairing got %0d bad want 0", data_err); end
        checks++; if (fe !== 1'b0) begin errors++; $display("FAIL odd_err got %b want 0", fe); end
    endtask

    task automatic test_enable;
        bit fd, fe;
        int dc;
        mode = 1;
        dc = done_cnt;
        run_frame(VP, -1, -1, 1'b0, 1'b0, fd, fe);
        checks++; if (wr_cnt != 0) begin errors++; $display("FAIL dis_writes got %0d want 0", wr_cnt); end
        checks++; if (fd !== 1'b0 || done_cnt != dc) begin errors++; $display("FAIL dis_done got fd=%b n=%0d want 0 %0d", fd, done_cnt, dc); end
        run_frame(VP, -1, -1, 1'b1, 1'b0, fd, fe);
        checks++; if (wr_cnt != HP * VP || data_err != 0) begin errors++; $display("FAIL resume got n=%0d d=%0d want %0d 0", wr_cnt, data_err, HP * VP); end
        checks++; if (fd !== 1'b1 || fe !== 1'b0) begin errors++; $display("FAIL resume_done got fd=%b fe=%b want 1 0", fd, fe); end
    endtask
`endif

    initial begin
        test_reset();
`ifdef CAM_DECIMATE_EN
        test_decimate();
`else
        test_clean_frame();
        test_pattern();
        test_reset_midframe();
        test_overflow();
        test_odd_line();
        test_enable();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
